// File: rtl/freq_sweep_scheduler.sv
// Steps a programmable divider through a table of rate codes, holding each for a dwell of lf_clock edges.
// Optional sticky interrupt on sweep completion or abort: define FSWEEP_IRQ_EN.
module freq_sweep_scheduler #(
   parameter  int DEPTH          = 8,
   parameter  int DWELL_W        = 8,
   parameter  int PRELOAD_CYCLES = 2,
   localparam int AW             = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [3:0]         wr_code,
   input  logic [DWELL_W-1:0] wr_dwell,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic [AW-1:0]      last_idx,
   input  logic               lf_clock,
`ifdef FSWEEP_IRQ_EN
   output logic               irq,
   input  logic               irq_clr,
`endif
   output logic [3:0]         sel_par_in,
   output logic               sel_load,
   output logic               busy,
   output logic [AW-1:0]      cur_idx,
   output logic               step_pulse,
   output logic               done
);

   localparam int PW = (PRELOAD_CYCLES < 2) ? 1 : $clog2(PRELOAD_CYCLES);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

   state_t               state_q, state_d;
   logic [3:0]           code_q  [DEPTH];
   logic [DWELL_W-1:0]   dwell_q [DEPTH];
   logic                 lf_q;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]        lcnt_q, lcnt_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [AW-1:0]        last_q, last_d;
   logic                 loop_q, loop_d;
   logic [3:0]           par_q, par_d;
   logic                 lf_edge;
   logic [DWELL_W-1:0]   dwell_cur;
   logic [DWELL_W-1:0]   dwell_m1;

   assign lf_edge   = lf_clock & ~lf_q;
   assign dwell_cur = dwell_q[idx_q];
   // Dwell of 0 completes on the first edge, same as dwell 1.
   assign dwell_m1  = (dwell_cur == '0) ? '0 : dwell_cur - DWELL_W'(1);
   assign busy      = (state_q == LOAD) || (state_q == RUN);
   assign cur_idx   = idx_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            code_q[i]  <= '0;
            dwell_q[i] <= '0;
         end
      end else if (wr_en && !busy) begin
         code_q[wr_addr]  <= wr_code;
         dwell_q[wr_addr] <= wr_dwell;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         lf_q    <= 1'b0;
         cnt_q   <= '0;
         lcnt_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         par_q   <= '0;
      end else begin
         state_q <= state_d;
         lf_q    <= lf_clock;
         cnt_q   <= cnt_d;
         lcnt_q  <= lcnt_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lcnt_d     = lcnt_q;
      idx_d      = idx_q;
      last_d     = last_q;
      loop_d     = loop_q;
      par_d      = par_q;
      sel_par_in = par_q;
      sel_load   = 1'b0;
      step_pulse = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               loop_d  = loop;
               last_d  = last_idx;
               idx_d   = '0;
               lcnt_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            sel_par_in = code_q[idx_q];
            par_d      = code_q[idx_q];
            if (stop) begin
               state_d = IDLE;
            end else if (lcnt_q == PW'(PRELOAD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               lcnt_d = lcnt_q + PW'(1);
            end
         end
         RUN: begin
            sel_load = 1'b1;
            if (stop) begin
               state_d = IDLE;
            end else if (lf_edge) begin
               if (cnt_q == dwell_m1) begin
                  step_pulse = 1'b1;
                  lcnt_d     = '0;
                  if (idx_q != last_q) begin
                     idx_d   = idx_q + AW'(1);
                     state_d = LOAD;
                  end else if (loop_q) begin
                     idx_d   = '0;
                     state_d = LOAD;
                  end else begin
                     state_d = FIN;
                  end
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef FSWEEP_IRQ_EN
   logic irq_q;
   logic irq_set;

   assign irq_set = (state_q == FIN) || (stop && busy);
   assign irq     = irq_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else if (irq_set) begin
         irq_q <= 1'b1;
      end else if (irq_clr) begin
         irq_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Scoreboard bench for freq_sweep_scheduler: stimulus pushes expected step/done events, a monitor pops them.
module tb_freq_sweep_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_code = '0;
   logic [7:0] wr_dwell = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop = 1'b0;
   logic [2:0] last_idx = '0;
   logic       lf_clock = 1'b0;
   logic [3:0] sel_par_in;
   logic       sel_load;
   logic       busy;
   logic [2:0] cur_idx;
   logic       step_pulse;
   logic       done;
`ifdef FSWEEP_IRQ_EN
   logic       irq;
   logic       irq_clr = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         is_done;
      logic [2:0] idx;
      logic [3:0] code;
   } ev_t;
   ev_t sbq[$];

   freq_sweep_scheduler #(.DEPTH(8), .DWELL_W(8), .PRELOAD_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_code(wr_code), .wr_dwell(wr_dwell), .start(start), .stop(stop),
      .loop(loop), .last_idx(last_idx), .lf_clock(lf_clock),
`ifdef FSWEEP_IRQ_EN
      .irq(irq), .irq_clr(irq_clr),
`endif
      .sel_par_in(sel_par_in), .sel_load(sel_load), .busy(busy),
      .cur_idx(cur_idx), .step_pulse(step_pulse), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every step/done the DUT presents must match the next queued event.
   always @(negedge clock) begin
      if (!reset && (step_pulse || done)) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got step=%0d done=%0d expected none", step_pulse, done);
         end else begin
            ev_t e;
            e = sbq.pop_front();
            chk("event_is_done", {31'd0, done}, {31'd0, e.is_done});
            if (!e.is_done) begin
               chk("step_idx", {29'd0, cur_idx}, {29'd0, e.idx});
               chk("step_code", {28'd0, sel_par_in}, {28'd0, e.code});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse();
      lf_clock = 1'b1;
      tick();
      lf_clock = 1'b0;
      tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] c, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dwell = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] li, input logic lp);
      start = 1'b1; last_idx = li; loop = lp;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_run();
      int n = 0;
      while (!sel_load && n < 50) begin
         tick();
         n++;
      end
      chk("run_reached", {31'd0, sel_load}, 32'd1);
   endtask

   task automatic run_entry(input logic [2:0] idx, input logic [3:0] code, input int n, input bit fin);
      ev_t e;
      wait_run();
      for (int i = 0; i < n - 1; i++) pulse();
      e.is_done = 1'b0; e.idx = idx; e.code = code;
      sbq.push_back(e);
      if (fin) begin
         e.is_done = 1'b1;
         sbq.push_back(e);
      end
      pulse();
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_sel_load"}, {31'd0, sel_load}, 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_par", {28'd0, sel_par_in}, 32'd0);
      chk_idle("rst");
      chk("rst_idx", {29'd0, cur_idx}, 32'd0);
      chk("rst_step", {31'd0, step_pulse}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // Single non-looping sweep: codes 3,7,12 with dwells 2,1,3.
      wr(3'd0, 4'd3, 8'd2);
      wr(3'd1, 4'd7, 8'd1);
      wr(3'd2, 4'd12, 8'd3);
      do_start(3'd2, 1'b0);
      chk("start_sel_load", {31'd0, sel_load}, 32'd0);
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_par", {28'd0, sel_par_in}, 32'd3);
      run_entry(3'd0, 4'd3, 2, 1'b0);
      run_entry(3'd1, 4'd7, 1, 1'b0);
      run_entry(3'd2, 4'd12, 3, 1'b1);
      chk_idle("after_done");
      chk("idle_par_hold", {28'd0, sel_par_in}, 32'd12);

      // Reset held 3 cycles in the middle of RUN.
      do_start(3'd2, 1'b0);
      wait_run();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("midrst_par", {28'd0, sel_par_in}, 32'd0);
      chk_idle("midrst");
      chk("midrst_idx", {29'd0, cur_idx}, 32'd0);
      do_start(3'd0, 1'b0);
      chk("midrst_restart_busy", {31'd0, busy}, 32'd1);
      chk("midrst_table_cleared", {28'd0, sel_par_in}, 32'd0);
      run_entry(3'd0, 4'd0, 1, 1'b1);

      // Dwell 0 behaves as one edge; LOAD lasts exactly two cycles.
      wr(3'd0, 4'd5, 8'd0);
      start = 1'b1; last_idx = 3'd0; loop = 1'b0;
      tick();
      start = 1'b0;
      n = 0;
      while (!sel_load && n < 20) begin
         n++;
         tick();
      end
      chk("load_cycles", n, 32'd2);
      run_entry(3'd0, 4'd5, 1, 1'b1);

      // Looping sweep over entries 0,1 with contention and stop.
      wr(3'd0, 4'd9, 8'd1);
      wr(3'd1, 4'd4, 8'd1);
      do_start(3'd1, 1'b1);
      run_entry(3'd0, 4'd9, 1, 1'b0);
      run_entry(3'd1, 4'd4, 1, 1'b0);
      run_entry(3'd0, 4'd9, 1, 1'b0);
      wait_run();
      chk("loop_idx", {29'd0, cur_idx}, 32'd1);
      chk("loop_par", {28'd0, sel_par_in}, 32'd4);
      wr(3'd0, 4'd15, 8'd7);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_idx", {29'd0, cur_idx}, 32'd1);
      chk("busy_start_load", {31'd0, sel_load}, 32'd1);
      // Stop coincides with a completing edge: stop wins, no step.
      lf_clock = 1'b1; stop = 1'b1;
      tick();
      lf_clock = 1'b0; stop = 1'b0;
      chk_idle("stop");
      tick();
      do_start(3'd0, 1'b0);
      chk("table_unchanged", {28'd0, sel_par_in}, 32'd9);
      run_entry(3'd0, 4'd9, 1, 1'b1);

      // start and stop together in IDLE.
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk_idle("start_stop_idle");

`ifdef FSWEEP_IRQ_EN
      chk("irq_after_done", {31'd0, irq}, 32'd1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      do_start(3'd0, 1'b0);
      wait_run();
      irq_clr = 1'b1;
      run_entry(3'd0, 4'd9, 1, 1'b1);
      irq_clr = 1'b0;
      chk("irq_set_wins", {31'd0, irq}, 32'd1);
`endif

      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("sb_drained", sbq.size(), 32'd0);
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
